sbox_share_arbiter: RTL



---
 rtl/sbox_share_arbiter_if.sv | 28 ++
 rtl/sbox_share_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sbox_share_arbiter_if.sv
// sbox_share_arbiter_if
//   Bundles the requester-side handshakes of sbox_share_arbiter.
//   master : requester side (drives v_i, addr_i, yumi_i)
//   slave  : arbiter side   (drives ready_o, v_o, data_o)
//   Signals (bit / byte slice i belongs to requester i):
//     v_i     request valid           ready_o  requester may present a request
//     addr_i  lookup byte per port    v_o      response valid
//     yumi_i  response consumed       data_o   S-box result per port
interface sbox_share_arbiter_if #(
    parameter int num_req_p = 2
);
    logic [num_req_p-1:0]   v_i;
    logic [8*num_req_p-1:0] addr_i;
    logic [num_req_p-1:0]   ready_o;
    logic [num_req_p-1:0]   v_o;
    logic [8*num_req_p-1:0] data_o;
    logic [num_req_p-1:0]   yumi_i;

    modport master (
        output v_i, addr_i, yumi_i,
        input  ready_o, v_o, data_o
    );

    modport slave (
        input  v_i, addr_i, yumi_i,
        output ready_o, v_o, data_o
    );
endinterface

// File: rtl/sbox_share_arbiter.sv
// sbox_share_arbiter
//   Shares one AES S-box table between num_req_p (2..4) requesters.
//   Accepted address is registered (stage A), the table is evaluated from
//   that register, and the result is registered into the tagged requester's
//   response buffer (stage B): accept in cycle t -> v_o in cycle t+2.
//   Each requester may have only one lookup outstanding (busy flag).
//   Ports:
//     clk_i    clock, rising edge
//     reset_i  asynchronous active-high reset
//     req_if   sbox_share_arbiter_if.slave (v_i/addr_i/ready_o, v_o/data_o/yumi_i)
//   Build option:
//     SBOX_SHARE_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                               undefined -> round-robin with last-grant pointer
module sbox_share_arbiter #(
    parameter int num_req_p = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    sbox_share_arbiter_if.slave req_if
);
    localparam int ptr_w_lp = (num_req_p > 2) ? 2 : 1;

    // Standard AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] sbox_lp = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [num_req_p-1:0]   busy_q;
    logic [num_req_p-1:0]   v_q;
    logic [8*num_req_p-1:0] data_q;
    logic [num_req_p-1:0]   eligible;
    logic [num_req_p-1:0]   grant;
    logic [7:0]             grant_addr;
    logic                   a_v_q;
    logic [num_req_p-1:0]   a_tag_q;
    logic [7:0]             a_addr_q;
    logic [7:0]             sbox_out;

    // ready_o is purely registered state gated by reset; no path from v_i/yumi_i.
    assign req_if.ready_o = ~busy_q & {num_req_p{~reset_i}};
    assign req_if.v_o     = v_q;
    assign req_if.data_o  = data_q;

    assign eligible = req_if.v_i & req_if.ready_o;

`ifdef SBOX_SHARE_FIXED_PRIO_EN
    // Scan from the top so the lowest eligible index is the last to overwrite.
    always_comb begin
        grant = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end
`else
    logic [ptr_w_lp-1:0] ptr_q;
    logic [ptr_w_lp-1:0] grant_idx;
    logic                found;

    // Offsets 1..num_req_p from the pointer; the pointer itself is tried last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 1; off <= num_req_p; off++) begin
            for (int i = 0; i < num_req_p; i++) begin
                if (!found && eligible[i] && (i == (int'(ptr_q) + off) % num_req_p)) begin
                    grant[i]  = 1'b1;
                    grant_idx = ptr_w_lp'(i);
                    found     = 1'b1;
                end
            end
        end
    end

    // Reset to the last index so requester 0 wins the first contest.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= ptr_w_lp'(num_req_p - 1);
        end else if (|grant) begin
            ptr_q <= grant_idx;
        end
    end
`endif

    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant[i]) begin
                grant_addr = req_if.addr_i[8*i +: 8];
            end
        end
    end

    assign sbox_out = sbox_lp[2047 - 8*int'(a_addr_q) -: 8];

    // No grant leaves a_v_q low, which is the stage-A bubble.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_v_q    <= 1'b0;
            a_tag_q  <= '0;
            a_addr_q <= '0;
            busy_q   <= '0;
            v_q      <= '0;
            data_q   <= '0;
        end else begin
            a_v_q    <= |grant;
            a_tag_q  <= grant;
            a_addr_q <= grant_addr;
            for (int i = 0; i < num_req_p; i++) begin
                // A grant needs ready_o, so it never coincides with a live response.
                if (grant[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (req_if.yumi_i[i] && v_q[i]) begin
                    busy_q[i] <= 1'b0;
                end

                if (a_v_q && a_tag_q[i]) begin
                    v_q[i]           <= 1'b1;
                    data_q[8*i +: 8] <= sbox_out;
                end else if (req_if.yumi_i[i] && v_q[i]) begin
                    v_q[i] <= 1'b0;
                end
            end
        end
    end
endmodule
